// File: rtl/vx_onehot_iterator_pkg.sv
// Shared definitions for the set-bit iterator: occupancy states and index-width helper.
package vx_onehot_iterator_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } iter_state_e;

  // Index width for an n-entry mask; a single entry still needs one bit.
  function automatic int log2up(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/vx_find_first.sv
// Combinational first-set-bit selector: lowest (REVERSE=0) or highest (REVERSE=1) set bit.
module vx_find_first
  import vx_onehot_iterator_pkg::*;
#(
  parameter int N       = 16,
  parameter bit REVERSE = 1'b0,
  parameter int LN      = log2up(N)
) (
  input  logic [N-1:0]  data_in,
  output logic [N-1:0]  onehot_out,
  output logic [LN-1:0] index_out,
  output logic          valid_out
);

  logic [N-1:0] ord_in;
  logic [N-1:0] ord_oh;

  // Highest-first is lowest-first on the bit-reversed mask.
  always_comb begin
    ord_in = '0;
    for (int unsigned i = 0; i < N; i++) begin
      ord_in[i] = REVERSE ? data_in[N-1-i] : data_in[i];
    end
  end

  assign ord_oh = ord_in & (~ord_in + N'(1));

  always_comb begin
    onehot_out = '0;
    for (int unsigned i = 0; i < N; i++) begin
      onehot_out[i] = REVERSE ? ord_oh[N-1-i] : ord_oh[i];
    end
  end

  always_comb begin
    index_out = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (onehot_out[i]) begin
        index_out = index_out | LN'(i);
      end
    end
  end

  assign valid_out = |data_in;

endmodule

// File: rtl/vx_onehot_iterator.sv
// Streaming set-bit iterator: serialises an accepted N-bit mask into one beat per set bit.
module vx_onehot_iterator
  import vx_onehot_iterator_pkg::*;
#(
  parameter int N       = 16,
  parameter bit REVERSE = 1'b0,
  parameter int LN      = log2up(N)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          valid_in,
  input  logic [N-1:0]  data_in,
  output logic          ready_in,
  output logic          valid_out,
  output logic [LN-1:0] index_out,
  output logic [N-1:0]  onehot_out,
  output logic          last_out,
  input  logic          ready_out
);

  logic [N-1:0]  pending;
  logic [N-1:0]  pending_next;
  logic [N-1:0]  remaining;
  logic [N-1:0]  sel_oh;
  logic [LN-1:0] sel_idx;
  logic          sel_valid;
  iter_state_e   state;

  vx_find_first #(
    .N       (N),
    .REVERSE (REVERSE),
    .LN      (LN)
  ) u_find_first (
    .data_in    (pending),
    .onehot_out (sel_oh),
    .index_out  (sel_idx),
    .valid_out  (sel_valid)
  );

  assign state     = (pending != '0) ? BUSY : IDLE;
  assign remaining = pending & ~sel_oh;

  assign valid_out  = sel_valid;
  assign onehot_out = sel_oh;
  assign index_out  = sel_idx;
  assign last_out   = sel_valid & (remaining == '0);

  // Accept overlaps consumption of the final beat so masks stream without a bubble.
  assign ready_in = (state == IDLE) | (valid_out & last_out & ready_out);

  always_comb begin
    pending_next = pending;
    if (valid_out && ready_out) begin
      pending_next = remaining;
    end
    if (valid_in && ready_in) begin
      pending_next = data_in;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending <= '0;
    end else begin
      pending <= pending_next;
    end
  end

endmodule

// File: tb/tb_vx_onehot_iterator.sv
// Directed and model-checked bench for vx_onehot_iterator, both selection orders at N=8.
module tb_vx_onehot_iterator;

  localparam int N  = 8;
  localparam int LN = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic          valid_in;
  logic [N-1:0]  data_in;
  logic          ready_out;

  logic          ready_in_f,  ready_in_r;
  logic          valid_out_f, valid_out_r;
  logic [LN-1:0] index_out_f, index_out_r;
  logic [N-1:0]  onehot_out_f, onehot_out_r;
  logic          last_out_f,  last_out_r;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  vx_onehot_iterator #(.N(N), .REVERSE(1'b0)) dut_fwd (
    .clk(clk), .reset(reset), .valid_in(valid_in), .data_in(data_in),
    .ready_in(ready_in_f), .valid_out(valid_out_f), .index_out(index_out_f),
    .onehot_out(onehot_out_f), .last_out(last_out_f), .ready_out(ready_out)
  );

  vx_onehot_iterator #(.N(N), .REVERSE(1'b1)) dut_rev (
    .clk(clk), .reset(reset), .valid_in(valid_in), .data_in(data_in),
    .ready_in(ready_in_r), .valid_out(valid_out_r), .index_out(index_out_r),
    .onehot_out(onehot_out_r), .last_out(last_out_r), .ready_out(ready_out)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Check one beat on both instances: forward index, reverse index, shared last flag.
  task automatic beat(input string tag, input int idx_f, input int idx_r, input logic last);
    check({tag, ".vf"}, 32'(valid_out_f), 32'd1);
    check({tag, ".vr"}, 32'(valid_out_r), 32'd1);
    check({tag, ".if"}, 32'(index_out_f), 32'(idx_f));
    check({tag, ".ir"}, 32'(index_out_r), 32'(idx_r));
    check({tag, ".of"}, 32'(onehot_out_f), 32'd1 << idx_f);
    check({tag, ".or"}, 32'(onehot_out_r), 32'd1 << idx_r);
    check({tag, ".lf"}, 32'(last_out_f), 32'(last));
    check({tag, ".lr"}, 32'(last_out_r), 32'(last));
  endtask

  task automatic quiet(input string tag);
    check({tag, ".vf"}, 32'(valid_out_f), 32'd0);
    check({tag, ".vr"}, 32'(valid_out_r), 32'd0);
    check({tag, ".if"}, 32'(index_out_f), 32'd0);
    check({tag, ".of"}, 32'(onehot_out_f), 32'd0);
    check({tag, ".lr"}, 32'(last_out_r), 32'd0);
    check({tag, ".rf"}, 32'(ready_in_f), 32'd1);
    check({tag, ".rr"}, 32'(ready_in_r), 32'd1);
  endtask

  function automatic int lowbit(input logic [N-1:0] m);
    for (int i = 0; i < N; i++) if (m[i]) return i;
    return 0;
  endfunction

  function automatic int highbit(input logic [N-1:0] m);
    for (int i = N - 1; i >= 0; i--) if (m[i]) return i;
    return 0;
  endfunction

  initial begin
    logic [N-1:0] pf, pr;
    logic         rdy_exp, acc;
    reset = 1'b1; valid_in = 1'b0; data_in = '0; ready_out = 1'b1;
    #1;
    quiet("rst");
    tick(); tick();
    reset = 1'b0;

    // Mask 1010_0110 with ready held: fwd 1,2,5,7 / rev 7,5,2,1.
    tick();
    valid_in = 1'b1; data_in = 8'hA6;
    tick();
    valid_in = 1'b0; #1;
    beat("t1b0", 1, 7, 1'b0);
    check("t1.ri", 32'(ready_in_f), 32'd0);
    tick(); #1; beat("t1b1", 2, 5, 1'b0);
    tick(); #1; beat("t1b2", 5, 2, 1'b0);
    tick(); #1; beat("t1b3", 7, 1, 1'b1);
    check("t1.ri_last", 32'(ready_in_f), 32'd1);
    tick(); #1; quiet("t1end");

    // Back-to-back 0x03 then 0x80 with valid_in held.
    valid_in = 1'b1; data_in = 8'h03;
    tick();
    data_in = 8'h80; #1;
    beat("t3b0", 0, 1, 1'b0);
    check("t3.ri0", 32'(ready_in_f), 32'd0);
    tick(); #1;
    beat("t3b1", 1, 0, 1'b1);
    check("t3.ri1f", 32'(ready_in_f), 32'd1);
    check("t3.ri1r", 32'(ready_in_r), 32'd1);
    tick();
    valid_in = 1'b0; #1;
    beat("t3b2", 7, 7, 1'b1);
    tick(); #1; quiet("t3end");

    // Backpressure on mask 0x11.
    ready_out = 1'b0; valid_in = 1'b1; data_in = 8'h11;
    tick();
    valid_in = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1; beat($sformatf("t4s%0d", c), 0, 4, 1'b0);
      check($sformatf("t4s%0d.ri", c), 32'(ready_in_f), 32'd0);
      tick();
    end
    ready_out = 1'b1; #1;
    beat("t4b0", 0, 4, 1'b0);
    tick(); #1; beat("t4b1", 4, 0, 1'b1);
    tick(); #1; quiet("t4end");

    // Zero mask is consumed without beats.
    valid_in = 1'b1; data_in = 8'h00;
    tick();
    valid_in = 1'b0; #1; quiet("t5a");
    tick(); #1; quiet("t5b");

    // Asynchronous reset mid-mask.
    valid_in = 1'b1; data_in = 8'hFF;
    tick();
    valid_in = 1'b0; #1;
    beat("t6b0", 0, 7, 1'b0);
    #2 reset = 1'b1;
    #1 quiet("t6rst");
    tick(); tick();
    reset = 1'b0;
    tick(); #1; quiet("t6post0");
    tick(); #1; quiet("t6post1");

    // Random handshake traffic against a per-cycle reference model.
    pf = '0; pr = '0;
    for (int c = 0; c < 80; c++) begin
      tick();
      valid_in  = 1'($urandom_range(0, 1));
      data_in   = N'($urandom_range(0, 255));
      ready_out = ($urandom_range(0, 3) != 0);
      #1;
      rdy_exp = (pf == '0) || (ready_out && $countones(pf) == 1);
      check("rnd.vf", 32'(valid_out_f), 32'(pf != '0));
      check("rnd.vr", 32'(valid_out_r), 32'(pr != '0));
      check("rnd.ri", 32'(ready_in_f), 32'(rdy_exp));
      if (pf != '0) begin
        check("rnd.if", 32'(index_out_f), 32'(lowbit(pf)));
        check("rnd.ir", 32'(index_out_r), 32'(highbit(pr)));
        check("rnd.lf", 32'(last_out_f), 32'($countones(pf) == 1));
        check("rnd.lr", 32'(last_out_r), 32'($countones(pr) == 1));
      end
      acc = valid_in && rdy_exp;
      if (ready_out && pf != '0) begin
        pf[lowbit(pf)]  = 1'b0;
        pr[highbit(pr)] = 1'b0;
      end
      if (acc) begin
        pf = data_in;
        pr = data_in;
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
